// File: rtl/ysyx_lsu_sq.sv
// ysyx_lsu_sq: store queue that holds committed stores and drains them to memory in order.
// Optional macro YSYX_SQ_FWD_EN lets full-word stores forward data to younger loads.
module ysyx_lsu_sq #(
  parameter int XLEN    = 32,
  parameter int SQ_SIZE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rou_valid,
  input  logic                       rou_store,
  input  logic [4:0]                 rou_alu,
  input  logic [XLEN-1:0]            rou_sq_waddr,
  input  logic [XLEN-1:0]            rou_sq_wdata,
  input  logic [XLEN-1:0]            rou_pc,
  output logic                       rou_sq_ready,
  output logic                       mem_wvalid,
  output logic [XLEN-1:0]            mem_waddr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [XLEN/8-1:0]          mem_wstrb,
  input  logic                       mem_wready,
  input  logic [XLEN-1:0]            ld_addr,
  output logic                       ld_conflict,
  output logic                       ld_fwd_valid,
  output logic [XLEN-1:0]            ld_fwd_data,
  output logic                       sq_empty,
  output logic [$clog2(SQ_SIZE):0]   sq_count
);

  localparam int AW = $clog2(SQ_SIZE);
  localparam int PW = AW + 1;
  localparam int SW = XLEN / 8;

  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [SQ_SIZE-1:0] vld_q;
  logic [XLEN-1:0] addr_q [SQ_SIZE];
  logic [XLEN-1:0] data_q [SQ_SIZE];
  logic [SW-1:0]   strb_q [SQ_SIZE];
  logic [XLEN-1:0] pc_q   [SQ_SIZE];

  logic [AW-1:0] hi;
  logic [AW-1:0] ti;
  logic          full;
  logic          empty;
  logic          enq;
  logic          pop;
  logic [SW-1:0] new_strb;

  assign hi    = head_q[AW-1:0];
  assign ti    = tail_q[AW-1:0];
  assign empty = (head_q == tail_q);
  assign full  = (hi == ti) && (head_q[AW] != tail_q[AW]);

  assign rou_sq_ready = !full;
  assign enq = rou_valid & rou_store & !full;
  assign pop = mem_wvalid & mem_wready;

  // Byte strobe for the incoming store from funct3 and the low address bits
  always_comb begin
    new_strb = '0;
    unique case (1'b1)
      (rou_alu[2:0] == 3'b000): new_strb = SW'(1) << rou_sq_waddr[1:0];
      (rou_alu[2:0] == 3'b001): new_strb = SW'(3) << rou_sq_waddr[1:0];
      (rou_alu[2:0] == 3'b010): new_strb = SW'(15);
      default:                  new_strb = '0;
    endcase
  end

  // Pointer and occupancy state; reset drops every pending store
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      if (enq) begin
        tail_q    <= tail_q + PW'(1);
        vld_q[ti] <= 1'b1;
      end
      if (pop) begin
        head_q    <= head_q + PW'(1);
        vld_q[hi] <= 1'b0;
      end
    end
  end

  // Entry payload, written at the tail on enqueue
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[ti] <= {rou_sq_waddr[XLEN-1:2], 2'b00};
      data_q[ti] <= rou_sq_wdata << {rou_sq_waddr[1:0], 3'b000};
      strb_q[ti] <= new_strb;
      pc_q[ti]   <= rou_pc;
    end
  end

  assign mem_wvalid = !empty;
  assign mem_waddr  = empty ? '0 : addr_q[hi];
  assign mem_wdata  = empty ? '0 : data_q[hi];
  assign mem_wstrb  = empty ? '0 : strb_q[hi];
  assign sq_empty   = empty;
  assign sq_count   = tail_q - head_q;

  logic          hit;
  logic          hit_full;
  logic [XLEN-1:0] hit_data;
  logic [AW-1:0] idx;

  // Scan oldest to youngest so the last match is the youngest store
  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < SQ_SIZE; k++) begin
      idx = hi + AW'(k);
      if (vld_q[idx] &&
          addr_q[idx][XLEN-1:2] == ld_addr[XLEN-1:2]) begin
        hit      = 1'b1;
        hit_full = &strb_q[idx];
        hit_data = data_q[idx];
      end
    end
  end

`ifdef YSYX_SQ_FWD_EN
  assign ld_fwd_valid = hit & hit_full;
  assign ld_fwd_data  = (hit & hit_full) ? hit_data : '0;
  assign ld_conflict  = hit & !hit_full;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
  assign ld_conflict  = hit;
`endif

  logic sq_unused;
  assign sq_unused = ^{rou_alu[4:3], ld_addr[1:0], pc_q[hi],
                       hit_data, hit_full};

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// tb_ysyx_lsu_sq: directed stimulus with a scoreboard-driven memory monitor.
// Expected memory writes are queued at issue and popped on each handshake.
module tb_ysyx_lsu_sq;

  logic        clock = 1'b0;
  logic        reset;
  logic        rou_valid;
  logic        rou_store;
  logic [4:0]  rou_alu;
  logic [31:0] rou_sq_waddr;
  logic [31:0] rou_sq_wdata;
  logic [31:0] rou_pc;
  logic        rou_sq_ready;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_wready;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        sq_empty;
  logic [2:0]  sq_count;

  ysyx_lsu_sq #(.XLEN(32), .SQ_SIZE(4)) dut (
    .clock(clock), .reset(reset),
    .rou_valid(rou_valid), .rou_store(rou_store), .rou_alu(rou_alu),
    .rou_sq_waddr(rou_sq_waddr), .rou_sq_wdata(rou_sq_wdata),
    .rou_pc(rou_pc), .rou_sq_ready(rou_sq_ready),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wready(mem_wready), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict), .ld_fwd_valid(ld_fwd_valid),
    .ld_fwd_data(ld_fwd_data), .sq_empty(sq_empty),
    .sq_count(sq_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && mem_wvalid && mem_wready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h expected none",
                 mem_waddr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("waddr", mem_waddr, mon_e.a);
        chk("wdata", mem_wdata, mon_e.d);
        chk("wstrb", 32'(mem_wstrb), 32'(mon_e.s));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input bit exp_out,
                     input logic [31:0] ea, input logic [31:0] ed,
                     input logic [3:0] es);
    wr_t w;
    rou_valid    = 1'b1;
    rou_store    = 1'b1;
    rou_alu      = {2'b00, f3};
    rou_sq_waddr = a;
    rou_sq_wdata = d;
    rou_pc       = a ^ 32'h0000_1000;
    if (exp_out) begin
      w.a = ea;
      w.d = ed;
      w.s = es;
      exp_q.push_back(w);
    end
    step();
    rou_valid = 1'b0;
    rou_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rou_valid = 0; rou_store = 0; rou_alu = 0;
    rou_sq_waddr = 0; rou_sq_wdata = 0; rou_pc = 0;
    mem_wready = 0; ld_addr = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(rou_sq_ready), 1);
    chk("rst_wvalid", 32'(mem_wvalid), 0);
    chk("rst_wstrb", 32'(mem_wstrb), 0);
    chk("rst_conflict", 32'(ld_conflict), 0);
    chk("rst_fwd_valid", 32'(ld_fwd_valid), 0);
    chk("rst_fwd_data", ld_fwd_data, 0);
    chk("rst_empty", 32'(sq_empty), 1);
    chk("rst_count", 32'(sq_count), 0);
    reset = 1'b0;
    step();

    // single SW drains next cycle
    mem_wready = 1'b1;
    enq(32'h8000_0004, 32'h1122_3344, 3'b010, 1,
        32'h8000_0004, 32'h1122_3344, 4'b1111);
    @(negedge clock);
    chk("sw_wvalid", 32'(mem_wvalid), 1);
    chk("sw_count", 32'(sq_count), 1);
    step();
    @(negedge clock);
    chk("sw_empty", 32'(sq_empty), 1);
    step();

    // SB then SH, lane-aligned, with an overlapping enqueue+pop
    enq(32'h8000_0003, 32'h0000_00AB, 3'b000, 1,
        32'h8000_0000, 32'hAB00_0000, 4'b1000);
    enq(32'h8000_0002, 32'h0000_BEEF, 3'b001, 1,
        32'h8000_0000, 32'hBEEF_0000, 4'b1100);
    @(negedge clock);
    chk("enq_pop_count", 32'(sq_count), 1);
    step();
    @(negedge clock);
    chk("sbsh_empty", 32'(sq_empty), 1);
    step();

    // non-store commit is ignored; unsupported funct3 writes strobe 0
    rou_valid = 1'b1;
    rou_store = 1'b0;
    rou_alu   = 5'b00010;
    rou_sq_waddr = 32'h8000_0020;
    step();
    rou_valid = 1'b0;
    enq(32'h8000_0010, 32'h0000_0055, 3'b011, 1,
        32'h8000_0010, 32'h0000_0055, 4'b0000);
    step();
    @(negedge clock);
    chk("misc_empty", 32'(sq_empty), 1);
    step();

    // fill to full with wrapped pointers, overflow store dropped
    mem_wready = 1'b0;
    enq(32'h200, 32'hA0, 3'b010, 1, 32'h200, 32'hA0, 4'hF);
    enq(32'h204, 32'hA1, 3'b010, 1, 32'h204, 32'hA1, 4'hF);
    enq(32'h208, 32'hA2, 3'b010, 1, 32'h208, 32'hA2, 4'hF);
    enq(32'h20C, 32'hA3, 3'b010, 1, 32'h20C, 32'hA3, 4'hF);
    enq(32'h210, 32'hA4, 3'b010, 0, 0, 0, 0);
    @(negedge clock);
    chk("full_ready", 32'(rou_sq_ready), 0);
    chk("full_count", 32'(sq_count), 4);
    step();

    // full: pop and store in the same cycle, store refused
    mem_wready = 1'b1;
    enq(32'h214, 32'hB0, 3'b010, 0, 0, 0, 0);
    mem_wready = 1'b0;
    @(negedge clock);
    chk("fullpop_count", 32'(sq_count), 3);
    chk("fullpop_ready", 32'(rou_sq_ready), 1);
    step();
    enq(32'h214, 32'hB1, 3'b010, 1, 32'h214, 32'hB1, 4'hF);
    @(negedge clock);
    chk("refill_count", 32'(sq_count), 4);
    step();
    mem_wready = 1'b1;
    repeat (6) step();
    @(negedge clock);
    chk("drain_empty", 32'(sq_empty), 1);
    chk("drain_count", 32'(sq_count), 0);
    step();

    // load hazard against a pending full word, then a partial store
    mem_wready = 1'b0;
    ld_addr = 32'h102;
    enq(32'h100, 32'hDEAD_BEEF, 3'b010, 1,
        32'h100, 32'hDEAD_BEEF, 4'hF);
    @(negedge clock);
`ifdef YSYX_SQ_FWD_EN
    chk("fwd_valid", 32'(ld_fwd_valid), 1);
    chk("fwd_data", ld_fwd_data, 32'hDEAD_BEEF);
    chk("fwd_conflict", 32'(ld_conflict), 0);
`else
    chk("nofwd_conflict", 32'(ld_conflict), 1);
    chk("nofwd_valid", 32'(ld_fwd_valid), 0);
    chk("nofwd_data", ld_fwd_data, 0);
`endif
    step();
    enq(32'h101, 32'h77, 3'b000, 1, 32'h100, 32'h0000_7700, 4'b0010);
    @(negedge clock);
    chk("partial_conflict", 32'(ld_conflict), 1);
    chk("partial_fwd_valid", 32'(ld_fwd_valid), 0);
    ld_addr = 32'h104;
    #1;
    chk("other_word_conflict", 32'(ld_conflict), 0);
    ld_addr = 32'h102;
    step();
    mem_wready = 1'b1;
    repeat (3) step();
    @(negedge clock);
    chk("drained_conflict", 32'(ld_conflict), 0);
    chk("drained_empty", 32'(sq_empty), 1);
    step();

    // reset with stores pending and head waiting on memory
    mem_wready = 1'b0;
    enq(32'h300, 32'hC0, 3'b010, 0, 0, 0, 0);
    enq(32'h304, 32'hC1, 3'b010, 0, 0, 0, 0);
    enq(32'h308, 32'hC2, 3'b010, 0, 0, 0, 0);
    @(negedge clock);
    chk("pre_rst_count", 32'(sq_count), 3);
    chk("pre_rst_wvalid", 32'(mem_wvalid), 1);
    step();
    mem_wready = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_wvalid", 32'(mem_wvalid), 0);
    chk("mid_rst_count", 32'(sq_count), 0);
    chk("mid_rst_empty", 32'(sq_empty), 1);
    step();
    reset = 1'b0;
    repeat (5) step();
    @(negedge clock);
    chk("post_rst_empty", 32'(sq_empty), 1);

    chk("scoreboard_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
